// File: rtl/cpu_pkg.sv
// Shared encodings for the 16-bit CPU control path: opcodes, ext codes,
// FSM states, write-back sources and the decoded control bundle.
package cpu_pkg;

  localparam logic [3:0] OP_RTYPE = 4'h0;
  localparam logic [3:0] OP_MEM   = 4'h4;
  localparam logic [3:0] OP_ADDI  = 4'h5;
  localparam logic [3:0] OP_MOVI  = 4'hD;

  localparam logic [3:0] EXT_LOAD = 4'h0;
  localparam logic [3:0] EXT_STOR = 4'h4;
  localparam logic [3:0] EXT_CMP  = 4'hB;
  localparam logic [3:0] EXT_JUMP = 4'hC;

  localparam logic [3:0]  ALU_ADD   = 4'h5;
  localparam logic [15:0] HALT_WORD = 16'hFFFF;

  typedef enum logic [2:0] {
    FETCH,
    DECODE,
    EXEC,
    MEM,
    HALT
  } cpuState_t;

  typedef enum logic [1:0] {
    WB_ALU = 2'd0,
    WB_MEM = 2'd1,
    WB_IMM = 2'd2
  } wbSrc_t;

  typedef struct packed {
    logic [3:0]  selectA;
    logic [3:0]  selectB;
    logic [3:0]  selectInput;
    logic [3:0]  aluOp;
    logic [15:0] imm;
    wbSrc_t      wbSrc;
    logic        bSrcImm;
    logic        writeReg;
    logic        isLoad;
    logic        isStore;
    logic        isJump;
    logic        isHalt;
    logic        illegal;
  } decode_t;

  function automatic logic [15:0] signExtend8(input logic [7:0] value);
    return {{8{value[7]}}, value};
  endfunction

endpackage

// File: rtl/instr_decoder.sv
// Combinational instruction decoder: maps the instruction register onto
// register selects, ALU controls, immediate and per-instruction flags.
module instr_decoder
  import cpu_pkg::*;
(
  input  logic [15:0] Ir,
  output decode_t     Decoded
);

  logic [3:0] opcode;
  logic [3:0] rdest;
  logic [3:0] ext;
  logic [3:0] rsrc;

  assign opcode = Ir[15:12];
  assign rdest  = Ir[11:8];
  assign ext    = Ir[7:4];
  assign rsrc   = Ir[3:0];

  always_comb begin
    Decoded             = '0;
    Decoded.selectA     = rdest;
    Decoded.selectB     = rsrc;
    Decoded.selectInput = rdest;
    Decoded.imm         = signExtend8(Ir[7:0]);
    Decoded.wbSrc       = WB_ALU;

    if (Ir == HALT_WORD) begin
      Decoded.isHalt = 1'b1;
    end else begin
      case (opcode)
        OP_RTYPE: begin
          Decoded.aluOp    = ext;
          Decoded.writeReg = (ext != EXT_CMP);
        end
        OP_ADDI: begin
          Decoded.aluOp    = ALU_ADD;
          Decoded.bSrcImm  = 1'b1;
          Decoded.writeReg = 1'b1;
        end
        OP_MOVI: begin
          Decoded.wbSrc    = WB_IMM;
          Decoded.writeReg = 1'b1;
        end
        OP_MEM: begin
          // Memory/jump group addresses through Rsrc on port A; STOR data comes from Rdest on B.
          Decoded.selectA = rsrc;
          Decoded.selectB = rdest;
          case (ext)
            EXT_LOAD: begin
              Decoded.isLoad = 1'b1;
              Decoded.wbSrc  = WB_MEM;
            end
            EXT_STOR: Decoded.isStore = 1'b1;
            EXT_JUMP: Decoded.isJump  = 1'b1;
            default:  Decoded.illegal = 1'b1;
          endcase
        end
        default: Decoded.illegal = 1'b1;
      endcase
    end
  end

endmodule

// File: rtl/datapath_controller.sv
// Multi-cycle control FSM for the 16-bit datapath: owns PC and IR, runs the
// fetch/decode/execute/memory sequence and strobes the register file.
module datapath_controller
  import cpu_pkg::*;
#(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        Clock,
  input  logic        Reset,
  input  logic [15:0] MemRdata,
  input  logic        MemReady,
  input  logic [15:0] RegA,
  output logic        MemReq,
  output logic        MemWrite,
  output logic        MemAddrSel,
  output logic [15:0] Pc,
  output logic [3:0]  SelectA,
  output logic [3:0]  SelectB,
  output logic [3:0]  SelectInput,
  output logic        WriteEnable,
  output logic [3:0]  AluOp,
  output logic        BSrcImm,
  output logic [15:0] Imm,
  output logic [1:0]  WbSrc,
  output logic        Halted,
  output logic        Illegal
);

  cpuState_t   state;
  cpuState_t   nextState;
  logic [15:0] ir;
  logic        resetHold;
  logic        fetchDone;
  decode_t     dec;

  instr_decoder uDecoder (
    .Ir      (ir),
    .Decoded (dec)
  );

  assign SelectA     = dec.selectA;
  assign SelectB     = dec.selectB;
  assign SelectInput = dec.selectInput;
  assign AluOp       = dec.aluOp;
  assign BSrcImm     = dec.bSrcImm;
  assign Imm         = dec.imm;
  assign WbSrc       = dec.wbSrc;

  // resetHold keeps the first FETCH cycle after reset quiet so no request overlaps reset.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state     <= FETCH;
      Pc        <= RESET_PC;
      ir        <= '0;
      resetHold <= 1'b1;
    end else begin
      state     <= nextState;
      resetHold <= 1'b0;
      if (fetchDone) begin
        ir <= MemRdata;
        Pc <= Pc + 16'd1;
      end else if (state == EXEC && dec.isJump) begin
        Pc <= RegA;
      end
    end
  end

  always_comb begin
    nextState   = state;
    MemReq      = 1'b0;
    MemWrite    = 1'b0;
    MemAddrSel  = 1'b0;
    WriteEnable = 1'b0;
    Halted      = 1'b0;
    Illegal     = 1'b0;
    fetchDone   = 1'b0;

    case (state)
      FETCH: begin
        MemReq    = !resetHold;
        fetchDone = !resetHold && MemReady;
        if (fetchDone) nextState = DECODE;
      end
      DECODE: begin
        Illegal   = dec.illegal;
        nextState = dec.isHalt ? HALT : EXEC;
      end
      EXEC: begin
        WriteEnable = dec.writeReg;
        nextState   = (dec.isLoad || dec.isStore) ? MEM : FETCH;
      end
      MEM: begin
        MemReq     = 1'b1;
        MemAddrSel = 1'b1;
        MemWrite   = dec.isStore;
        if (MemReady) begin
          WriteEnable = dec.isLoad;
          nextState   = FETCH;
        end
      end
      HALT: begin
        Halted = 1'b1;
      end
      default: nextState = FETCH;
    endcase
  end

endmodule

// File: tb/tb_datapath_controller.sv
// Self-checking bench for datapath_controller: directed instruction sequences
// with a write-back scoreboard checked whenever the register file is strobed.
module tb_datapath_controller;

  logic        Clock;
  logic        Reset;
  logic [15:0] MemRdata;
  logic        MemReady;
  logic [15:0] RegA;
  logic        MemReq;
  logic        MemWrite;
  logic        MemAddrSel;
  logic [15:0] Pc;
  logic [3:0]  SelectA;
  logic [3:0]  SelectB;
  logic [3:0]  SelectInput;
  logic        WriteEnable;
  logic [3:0]  AluOp;
  logic        BSrcImm;
  logic [15:0] Imm;
  logic [1:0]  WbSrc;
  logic        Halted;
  logic        Illegal;

  datapath_controller #(.RESET_PC(16'h0000)) uDut (
    .Clock       (Clock),
    .Reset       (Reset),
    .MemRdata    (MemRdata),
    .MemReady    (MemReady),
    .RegA        (RegA),
    .MemReq      (MemReq),
    .MemWrite    (MemWrite),
    .MemAddrSel  (MemAddrSel),
    .Pc          (Pc),
    .SelectA     (SelectA),
    .SelectB     (SelectB),
    .SelectInput (SelectInput),
    .WriteEnable (WriteEnable),
    .AluOp       (AluOp),
    .BSrcImm     (BSrcImm),
    .Imm         (Imm),
    .WbSrc       (WbSrc),
    .Halted      (Halted),
    .Illegal     (Illegal)
  );

  initial Clock = 1'b0;
  always #5 Clock = ~Clock;

  int testsRun    = 0;
  int testsFailed = 0;

  typedef struct {
    logic [3:0] sel;
    logic [1:0] wb;
  } wrExp_t;

  wrExp_t      sb[$];
  logic [15:0] expPc;

  task automatic checkVal(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    testsRun++;
    if (obs !== exp) begin
      testsFailed++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic nextCycle();
    @(posedge Clock);
    #1;
  endtask

  task automatic waitReq(input string tag);
    for (int i = 0; i < 16; i++) begin
      if (MemReq) break;
      nextCycle();
    end
    checkVal(tag, {15'b0, MemReq}, 16'd1);
  endtask

  // Leaves the bench at DECODE of the fetched instruction.
  task automatic fetchInstr(input logic [15:0] instr, input int unsigned delay, input logic [15:0] pcAt);
    logic [15:0] pcNext;
    waitReq("fetchReq");
    checkVal("fetchPc", Pc, pcAt);
    checkVal("fetchAddrSel", {15'b0, MemAddrSel}, 16'd0);
    for (int unsigned i = 0; i < delay; i++) begin
      nextCycle();
      checkVal("fetchHold", {15'b0, MemReq}, 16'd1);
    end
    MemRdata = instr;
    MemReady = 1'b1;
    nextCycle();
    MemReady = 1'b0;
    MemRdata = 16'h0;
    #1;
    pcNext = pcAt + 16'd1;
    checkVal("decodePc", Pc, pcNext);
  endtask

  task automatic pushWrite(input logic [3:0] sel, input logic [1:0] wb);
    wrExp_t e;
    e.sel = sel;
    e.wb  = wb;
    sb.push_back(e);
  endtask

  always @(negedge Clock) begin
    if (!Reset && WriteEnable) begin
      checkVal("sbPending", {15'b0, (sb.size() != 0)}, 16'd1);
      if (sb.size() != 0) begin
        wrExp_t e;
        e = sb.pop_front();
        checkVal("wrSel", {12'b0, SelectInput}, {12'b0, e.sel});
        checkVal("wrSrc", {14'b0, WbSrc}, {14'b0, e.wb});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    Reset    = 1'b1;
    MemRdata = 16'h0;
    MemReady = 1'b0;
    RegA     = 16'h0;
    nextCycle();
    nextCycle();
    checkVal("rstPc", Pc, 16'h0000);
    checkVal("rstMemReq", {15'b0, MemReq}, 16'd0);
    checkVal("rstWe", {15'b0, WriteEnable}, 16'd0);
    checkVal("rstHalted", {15'b0, Halted}, 16'd0);
    checkVal("rstIllegal", {15'b0, Illegal}, 16'd0);
    checkVal("rstSelA", {12'b0, SelectA}, 16'd0);
    checkVal("rstImm", Imm, 16'h0000);
    checkVal("rstAluWb", {10'b0, AluOp, WbSrc}, 16'd0);
    Reset = 1'b0;
    expPc = 16'h0000;

    // ADD r3,r1
    pushWrite(4'd3, 2'd0);
    fetchInstr(16'h0351, 0, expPc);
    checkVal("addSelA", {12'b0, SelectA}, 16'd3);
    checkVal("addSelB", {12'b0, SelectB}, 16'd1);
    checkVal("addAluOp", {12'b0, AluOp}, 16'd5);
    checkVal("addDecWe", {15'b0, WriteEnable}, 16'd0);
    nextCycle();
    checkVal("addExWe", {15'b0, WriteEnable}, 16'd1);
    checkVal("addExSelIn", {12'b0, SelectInput}, 16'd3);
    checkVal("addExWb", {14'b0, WbSrc}, 16'd0);
    nextCycle();
    checkVal("addBackToFetch", {15'b0, MemReq}, 16'd1);
    expPc = 16'h0001;

    // MOVI r2,-1
    pushWrite(4'd2, 2'd2);
    fetchInstr(16'hD2FF, 0, expPc);
    nextCycle();
    checkVal("moviImm", Imm, 16'hFFFF);
    checkVal("moviWb", {14'b0, WbSrc}, 16'd2);
    checkVal("moviWe", {15'b0, WriteEnable}, 16'd1);
    checkVal("moviSelIn", {12'b0, SelectInput}, 16'd2);
    expPc = 16'h0002;

    // ADDI r3,-16 with a two-cycle fetch wait
    pushWrite(4'd3, 2'd0);
    fetchInstr(16'h53F0, 2, expPc);
    nextCycle();
    checkVal("addiBImm", {15'b0, BSrcImm}, 16'd1);
    checkVal("addiAluOp", {12'b0, AluOp}, 16'd5);
    checkVal("addiImm", Imm, 16'hFFF0);
    checkVal("addiWe", {15'b0, WriteEnable}, 16'd1);
    expPc = 16'h0003;

    // CMP r1,r2 : no write-back
    fetchInstr(16'h01B2, 0, expPc);
    checkVal("cmpAluOp", {12'b0, AluOp}, 16'h000B);
    checkVal("cmpSels", {8'b0, SelectA, SelectB}, 16'h0012);
    nextCycle();
    checkVal("cmpWe", {15'b0, WriteEnable}, 16'd0);
    expPc = 16'h0004;

    // LOAD r7,[r2] with three wait cycles in MEM
    pushWrite(4'd7, 2'd1);
    fetchInstr(16'h4702, 0, expPc);
    checkVal("loadSelA", {12'b0, SelectA}, 16'd2);
    checkVal("loadIllegal", {15'b0, Illegal}, 16'd0);
    nextCycle();
    checkVal("loadExWe", {15'b0, WriteEnable}, 16'd0);
    checkVal("loadExReq", {15'b0, MemReq}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      nextCycle();
      checkVal("loadWaitReq", {15'b0, MemReq}, 16'd1);
      checkVal("loadWaitAddr", {15'b0, MemAddrSel}, 16'd1);
      checkVal("loadWaitWr", {15'b0, MemWrite}, 16'd0);
      checkVal("loadWaitWe", {15'b0, WriteEnable}, 16'd0);
    end
    nextCycle();
    MemReady = 1'b1;
    MemRdata = 16'h1234;
    #1;
    checkVal("loadReadyWe", {15'b0, WriteEnable}, 16'd1);
    checkVal("loadReadyWb", {14'b0, WbSrc}, 16'd1);
    nextCycle();
    MemReady = 1'b0;
    MemRdata = 16'h0;
    #1;
    checkVal("loadDoneAddr", {15'b0, MemAddrSel}, 16'd0);
    checkVal("loadDoneWe", {15'b0, WriteEnable}, 16'd0);
    expPc = 16'h0005;

    // JUMP r4 -> 0x0040
    fetchInstr(16'h40C4, 0, expPc);
    checkVal("jumpSelA", {12'b0, SelectA}, 16'd4);
    RegA = 16'h0040;
    nextCycle();
    checkVal("jumpExWe", {15'b0, WriteEnable}, 16'd0);
    nextCycle();
    checkVal("jumpPc", Pc, 16'h0040);
    expPc = 16'h0040;

    // JUMP to 0xFFFF, then an undefined word there: Pc wraps to 0
    fetchInstr(16'h40C4, 0, expPc);
    RegA = 16'hFFFF;
    nextCycle();
    nextCycle();
    checkVal("jumpPcTop", Pc, 16'hFFFF);
    RegA = 16'h0000;
    expPc = 16'hFFFF;
    fetchInstr(16'h7123, 0, expPc);
    checkVal("illegalPulse", {15'b0, Illegal}, 16'd1);
    nextCycle();
    checkVal("illegalEnd", {15'b0, Illegal}, 16'd0);
    checkVal("illegalWe", {15'b0, WriteEnable}, 16'd0);
    checkVal("illegalReq", {15'b0, MemReq}, 16'd0);
    expPc = 16'h0000;

    // STOR r3,[r5], reset while the store waits in MEM
    fetchInstr(16'h4345, 0, expPc);
    checkVal("storSels", {8'b0, SelectA, SelectB}, 16'h0053);
    nextCycle();
    for (int i = 0; i < 2; i++) begin
      nextCycle();
      checkVal("storWaitWr", {15'b0, MemWrite}, 16'd1);
      checkVal("storWaitAddr", {15'b0, MemAddrSel}, 16'd1);
      checkVal("storWaitWe", {15'b0, WriteEnable}, 16'd0);
    end
    Reset = 1'b1;
    nextCycle();
    Reset = 1'b0;
    #1;
    checkVal("rstMemPc", Pc, 16'h0000);
    checkVal("rstMemReq", {15'b0, MemReq}, 16'd0);
    checkVal("rstMemWe", {15'b0, WriteEnable}, 16'd0);
    checkVal("rstMemAddr", {15'b0, MemAddrSel}, 16'd0);
    nextCycle();
    checkVal("rstMemFetchReq", {15'b0, MemReq}, 16'd1);
    checkVal("rstMemFetchAddr", {15'b0, MemAddrSel}, 16'd0);
    checkVal("rstMemFetchWr", {15'b0, MemWrite}, 16'd0);
    expPc = 16'h0000;

    // HALT: stays put for 20 cycles even with stray MemReady
    fetchInstr(16'hFFFF, 0, expPc);
    checkVal("haltDecode", {15'b0, Halted}, 16'd0);
    for (int i = 0; i < 20; i++) begin
      nextCycle();
      MemReady = 1'($urandom_range(0, 1));
      #1;
      checkVal("haltHeld", {15'b0, Halted}, 16'd1);
      checkVal("haltReq", {15'b0, MemReq}, 16'd0);
      checkVal("haltWe", {15'b0, WriteEnable}, 16'd0);
    end
    MemReady = 1'b0;
    Reset = 1'b1;
    nextCycle();
    Reset = 1'b0;
    #1;
    checkVal("haltRstPc", Pc, 16'h0000);
    checkVal("haltRstHalted", {15'b0, Halted}, 16'd0);
    checkVal("haltRstReq", {15'b0, MemReq}, 16'd0);
    expPc = 16'h0000;

    // Normal operation resumes after recovery
    pushWrite(4'd3, 2'd0);
    fetchInstr(16'h0351, 0, expPc);
    nextCycle();
    checkVal("recoverWe", {15'b0, WriteEnable}, 16'd1);
    nextCycle();
    nextCycle();

    checkVal("sbDrain", 16'(sb.size()), 16'd0);
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
